ysyx_lsu: RTL

Load/store stage directly downstream of the execute stage. It accepts one instruction per handshake, carrying the ALU result/address, store data, func3 and the memory/writeback controls. It runs a single memory transaction on a simple request/response bus, aligns store data and sign/zero-extends load data. It hands the writeback value to the WBU through a valid/ready handshake; non-memory instructions pass straight through.

---
 rtl/ysyx_lsu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit between the execute stage and writeback.
// Takes one instruction per in_valid/in_ready handshake and runs at most one
// bus transaction for it. Store data is lane-aligned and load data is
// sign- or zero-extended. The result goes to the WBU over out_valid/out_ready.
//
// Optional build macro: YSYX_LSU_MISALIGN_CHK_EN
//   When defined, a misaligned halfword or word access raises out_err and
//   issues no bus request. When undefined, every access goes to the bus.
//
// Handshake rule, used on every interface: a transfer happens on a rising
// edge where valid and ready are both high. A valid, once raised, stays high
// and keeps its payload stable until that transfer. The one exception is
// mem_rsp_valid, which has no ready and is consumed only while in WAIT.
module ysyx_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [2:0]        in_func3,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_rd_we,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rd_we,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic              wen_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [DATA_W-1:0] out_wdata_q;
  logic              out_rd_we_q;
  logic              out_err_q;

  logic              is_mem;
  logic              misalign;
  logic [3:0]        base_mask;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] ld_data;

  // A store takes priority when both read and write are set.
  assign is_mem   = in_mem_read | in_mem_write;
  assign st_wstrb = base_mask << in_addr[1:0];
  assign st_wdata = in_wdata << {in_addr[1:0], 3'b000};
  assign ld_sh    = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

`ifdef YSYX_LSU_MISALIGN_CHK_EN
  // Misaligned halfword (001/101) or word (010) access.
  always_comb begin
    misalign = ((in_func3[1:0] == 2'b01) && in_addr[0]) ||
               ((in_func3 == 3'b010) && (in_addr[1:0] != 2'b00));
  end
`else
  // Misaligned accesses go to the bus like any other access.
  always_comb begin
    misalign = 1'b0;
  end
`endif

  // Byte-enable pattern for the store width, before lane shifting.
  always_comb begin
    base_mask = 4'b0000;
    case (in_func3)
      3'b000:  base_mask = 4'b0001;
      3'b001:  base_mask = 4'b0011;
      3'b010:  base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  end

  // Load extension from the lane-shifted response word.
  always_comb begin
    ld_data = ld_sh;
    case (func3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_sh[7:0]};
      3'b001:  ld_data = {{(DATA_W-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (is_mem && !misalign) ? REQ : DONE;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the instruction on accept and the formatted result on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      func3_q     <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      wstrb_q     <= '0;
      req_wdata_q <= '0;
      out_wdata_q <= '0;
      out_rd_we_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            addr_q      <= in_addr;
            func3_q     <= in_func3;
            rd_q        <= in_rd;
            wen_q       <= in_mem_write;
            wstrb_q     <= in_mem_write ? st_wstrb : 4'b0000;
            req_wdata_q <= in_mem_write ? st_wdata : '0;
            out_rd_we_q <= in_rd_we & (in_rd != 5'd0);
            out_err_q   <= 1'b0;
            if (is_mem && misalign) begin
              out_err_q   <= 1'b1;
              out_wdata_q <= '0;
              out_rd_we_q <= 1'b0;
            end else if (!is_mem) begin
              out_wdata_q <= DATA_W'(in_addr);
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              out_err_q   <= 1'b1;
              out_wdata_q <= '0;
              out_rd_we_q <= 1'b0;
            end else if (wen_q) begin
              out_wdata_q <= DATA_W'(addr_q);
            end else begin
              out_wdata_q <= ld_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == DONE);
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign out_rd        = rd_q;
  assign out_rd_we     = out_rd_we_q;
  assign out_wdata     = out_wdata_q;
  assign out_err       = out_err_q;

endmodule
